// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS core memory-side blocks.
// Includes the arbiter state/grant enums and the byte-lane word type.
package mips_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int MEM_LAT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        D_RD  = 2'd2,
        D_WR  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_t;

    // Element 0 sits in the most significant byte of the packed vector.
    typedef logic [0:3][7:0] byte_word_t;

    function automatic logic [31:0] bytes_to_word(input byte_word_t b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times the memory read latency.
// It stops at zero and asserts zero while it is there.
module mem_lat_counter
    import mips_pkg::*;
#(
    parameter  int MEM_LAT = MEM_LAT_DEF,
    localparam int CW      = $clog2(MEM_LAT) + 1
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] cnt_r;

    // Count register: load on accept, otherwise decrement down to zero.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            cnt_r <= CW'(0);
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != CW'(0)) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == CW'(0));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single byte-lane memory port between instruction fetch and
// load/store, granting one requester at a time with alternating priority.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            halted,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_valid,
    output logic [XLEN-1:0] if_data,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [0:3][7:0] d_wdata,
    output logic            d_done,
    output logic [0:3][7:0] d_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [0:3][7:0] mem_data_in,
    output logic            mem_write_en,
    input  logic [0:3][7:0] mem_data_out,
    output logic            busy
);

    localparam int CW = $clog2(MEM_LAT) + 1;

    arb_state_t      state_r;
    arb_state_t      state_s;
    grant_t          last_grant_r;
    grant_t          grant_s;
    logic            accept_s;
    logic            cnt_load_s;
    logic            cnt_zero_s;
    logic            if_cap_s;
    logic            d_cap_s;
    logic            if_valid_r;
    logic            d_done_r;
    logic [XLEN-1:0] if_data_r;
    byte_word_t      d_rdata_r;
    logic [XLEN-1:0] mem_addr_r;
    byte_word_t      mem_data_in_r;
    logic            mem_write_en_r;

    mem_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk      (clk),
        .rst_b    (rst_b),
        .load     (cnt_load_s),
        .load_val (CW'(MEM_LAT - 1)),
        .zero     (cnt_zero_s)
    );

    assign if_cap_s = (state_r == IF_RD) && cnt_zero_s;
    assign d_cap_s  = (state_r == D_RD) && cnt_zero_s;

    // Next-state and grant selection.
    always_comb begin
        state_s    = state_r;
        grant_s    = last_grant_r;
        accept_s   = 1'b0;
        cnt_load_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!halted && (if_req || d_req)) begin
                    accept_s = 1'b1;
                    if (if_req && d_req) begin
                        grant_s = (last_grant_r == GRANT_IF) ? GRANT_D : GRANT_IF;
                    end else if (d_req) begin
                        grant_s = GRANT_D;
                    end else begin
                        grant_s = GRANT_IF;
                    end
                    if (grant_s == GRANT_IF) begin
                        state_s = IF_RD;
                    end else if (d_we) begin
                        state_s = D_WR;
                    end else begin
                        state_s = D_RD;
                    end
                    cnt_load_s = (state_s != D_WR);
                end else begin
                    state_s = IDLE;
                end
            end
            IF_RD, D_RD: begin
                if (cnt_zero_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            D_WR: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, grant history and completion pulses.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_r      <= IDLE;
            last_grant_r <= GRANT_IF;
            if_valid_r   <= 1'b0;
            d_done_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            last_grant_r <= grant_s;
            if_valid_r   <= if_cap_s;
            d_done_r     <= d_cap_s || (state_r == D_WR);
        end
    end

    // Memory-side drive: captured operands for the life of a transaction, zero when idle.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            mem_addr_r     <= {XLEN{1'b0}};
            mem_data_in_r  <= 32'h0000_0000;
            mem_write_en_r <= 1'b0;
        end else if (accept_s) begin
            mem_addr_r     <= (grant_s == GRANT_IF) ? if_addr : d_addr;
            mem_write_en_r <= (state_s == D_WR);
            mem_data_in_r  <= (state_s == D_WR) ? d_wdata : 32'h0000_0000;
        end else if (state_s == IDLE) begin
            mem_addr_r     <= {XLEN{1'b0}};
            mem_data_in_r  <= 32'h0000_0000;
            mem_write_en_r <= 1'b0;
        end else begin
            mem_addr_r     <= mem_addr_r;
            mem_data_in_r  <= mem_data_in_r;
            mem_write_en_r <= mem_write_en_r;
        end
    end

    // Read data capture; values hold until the next read completes.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            if_data_r <= {XLEN{1'b0}};
            d_rdata_r <= 32'h0000_0000;
        end else begin
            if (if_cap_s) begin
                if_data_r <= XLEN'(bytes_to_word(mem_data_out));
            end else begin
                if_data_r <= if_data_r;
            end
            if (d_cap_s) begin
                d_rdata_r <= mem_data_out;
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

    assign if_valid     = if_valid_r;
    assign d_done       = d_done_r;
    assign if_data      = if_data_r;
    assign d_rdata      = d_rdata_r;
    assign mem_addr     = mem_addr_r;
    assign mem_data_in  = mem_data_in_r;
    assign mem_write_en = mem_write_en_r;
    assign busy         = (state_r != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance for the main
// scenarios and a MEM_LAT=1 instance for back-to-back fetches.
module tb_mem_port_arbiter;
    import mips_pkg::*;

    typedef struct {
        bit          is_if;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic        rst_b, halted, if_req, d_req, d_we, if_valid, d_done, mem_write_en, busy;
    logic [31:0] if_addr, d_addr, if_data, mem_addr;
    byte_word_t  d_wdata, d_rdata, mem_data_in, mem_data_out;

    logic        if_req1, if_valid1, d_done1, mem_write_en1, busy1;
    logic [31:0] if_addr1, if_data1, mem_addr1;
    byte_word_t  d_rdata1, mem_data_in1, mem_data_out1;
    byte_word_t  zero_w = 32'h0000_0000;
    logic [31:0] zero_a = 32'h0000_0000;

    // Memory model: fixed contents plus the most recent write.
    logic        wr_valid = 1'b0;
    logic [31:0] wr_addr  = 32'h0000_0000;
    byte_word_t  wr_data  = 32'h0000_0000;
    always @(posedge clk) begin
        if (mem_write_en) begin
            wr_valid <= 1'b1;
            wr_addr  <= mem_addr;
            wr_data  <= mem_data_in;
        end
    end

    function automatic byte_word_t mem_rd(input logic [31:0] a);
        if (wr_valid && a == wr_addr) return wr_data;
        case (a)
            32'h0000_0010: return 32'h2008_0005;
            32'h0000_0020: return 32'h1122_3344;
            32'h0000_0024: return 32'h0BAD_CAFE;
            default:       return {a[7:0], ~a[7:0], 8'hA5, 8'h5A};
        endcase
    endfunction

    assign mem_data_out  = mem_rd(mem_addr);
    assign mem_data_out1 = mem_rd(mem_addr1);

    mem_port_arbiter #(.XLEN(32), .MEM_LAT(2)) u_dut (
        .clk(clk), .rst_b(rst_b), .halted(halted),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    mem_port_arbiter #(.XLEN(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst_b(rst_b), .halted(1'b0),
        .if_req(if_req1), .if_addr(if_addr1), .if_valid(if_valid1), .if_data(if_data1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(zero_a), .d_wdata(zero_w),
        .d_done(d_done1), .d_rdata(d_rdata1),
        .mem_addr(mem_addr1), .mem_data_in(mem_data_in1), .mem_write_en(mem_write_en1),
        .mem_data_out(mem_data_out1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push0(input bit is_if, input bit chk, input logic [31:0] d, input int c);
        exp_t e;
        e.is_if = is_if; e.chk_data = chk; e.data = d; e.cyc = c;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [31:0] d, input int c);
        exp_t e;
        e.is_if = 1'b1; e.chk_data = 1'b1; e.data = d; e.cyc = c;
        q1.push_back(e);
    endtask

    // Scoreboard: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_b === 1'b0 && (if_valid || d_done)) begin
            check("pulse_exclusive", 32'(if_valid & d_done), 32'd0);
            check("pulse_expected", 32'(q0.size() == 0), 32'd0);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("pulse_kind", 32'(if_valid), 32'(e.is_if));
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                if (e.chk_data) check("pulse_data", e.is_if ? if_data : 32'(d_rdata), e.data);
            end
        end
        if (rst_b === 1'b0 && (if_valid1 || d_done1)) begin
            check("lat1_expected", 32'(q1.size() == 0), 32'd0);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("lat1_cycle", 32'(cyc), 32'(e.cyc));
                check("lat1_data", if_data1, e.data);
            end
        end
    end

    initial begin
        rst_b = 1'b1; halted = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; if_req1 = 1'b0; if_addr1 = 32'h0;
        tick(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_we", 32'(mem_write_en), 32'd0);
        check("rst_pulses", 32'(if_valid | d_done), 32'd0);
        check("rst_if_data", if_data, 32'h0);
        rst_b = 1'b0;
        tick(1);

        // single fetch
        if_req = 1'b1; if_addr = 32'h10; push0(1'b1, 1'b1, 32'h2008_0005, cyc + 3);
        tick(1);
        check("fetch_busy", 32'(busy), 32'd1);
        check("fetch_mem_addr", mem_addr, 32'h10);
        check("fetch_we", 32'(mem_write_en), 32'd0);
        tick(2);
        if_req = 1'b0;
        check("fetch_pulse_idle", 32'(busy), 32'd0);
        tick(1);
        check("fetch_hold", if_data, 32'h2008_0005);
        check("fetch_idle_addr", mem_addr, 32'h0);

        // store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        push0(1'b0, 1'b0, 32'h0, cyc + 2);
        tick(1);
        check("store_we", 32'(mem_write_en), 32'd1);
        check("store_addr", mem_addr, 32'h40);
        check("store_data", 32'(mem_data_in), 32'hDEAD_BEEF);
        tick(1);
        d_req = 1'b0; d_we = 1'b0;
        check("store_we_off", 32'(mem_write_en), 32'd0);
        check("store_data_off", 32'(mem_data_in), 32'h0);
        tick(1);

        // load back the stored word
        d_req = 1'b1; d_addr = 32'h40; push0(1'b0, 1'b1, 32'hDEAD_BEEF, cyc + 3);
        tick(1);
        check("load_addr", mem_addr, 32'h40);
        tick(2);
        d_req = 1'b0;
        tick(1);

        // reset in the second D_RD cycle
        d_req = 1'b1; d_addr = 32'h44;
        tick(2);
        rst_b = 1'b1; d_req = 1'b0;
        tick(1);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(d_done), 32'd0);
        check("rstmid_addr", mem_addr, 32'h0);
        check("rstmid_rdata", 32'(d_rdata), 32'h0);
        rst_b = 1'b0;
        tick(1);
        check("rstmid_no_pulse", 32'(d_done), 32'd0);

        // contention: data first after reset, then alternate
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
        push0(1'b0, 1'b1, 32'h0BAD_CAFE, cyc + 3);
        push0(1'b1, 1'b1, 32'h2008_0005, cyc + 6);
        push0(1'b0, 1'b1, 32'h0BAD_CAFE, cyc + 9);
        push0(1'b1, 1'b1, 32'h2008_0005, cyc + 12);
        tick(12);
        if_req = 1'b0; d_req = 1'b0;
        tick(1);
        check("cont_idle", 32'(busy), 32'd0);

        // halt during a fetch
        if_req = 1'b1; if_addr = 32'h20; push0(1'b1, 1'b1, 32'h1122_3344, cyc + 3);
        tick(1);
        halted = 1'b1; d_req = 1'b1; d_addr = 32'h24;
        check("halt_inflight", 32'(busy), 32'd1);
        tick(2);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("halt_idle", 32'(busy), 32'd0);
        end
        if_req = 1'b0; d_req = 1'b0; halted = 1'b0;
        tick(1);

        // MEM_LAT=1 back-to-back fetches
        if_req1 = 1'b1; if_addr1 = 32'h10;
        push1(32'h2008_0005, cyc + 2);
        push1(32'h1122_3344, cyc + 4);
        push1(32'h0BAD_CAFE, cyc + 6);
        tick(1);
        check("lat1_addr0", mem_addr1, 32'h10);
        tick(1);
        if_addr1 = 32'h20;
        check("lat1_gap", 32'(busy1), 32'd0);
        tick(1);
        check("lat1_addr1", mem_addr1, 32'h20);
        tick(1);
        if_addr1 = 32'h24;
        tick(2);
        if_req1 = 1'b0;
        tick(2);

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares the single byte-lane memory port between the instruction-fetch path and the load/store path of the MIPS core. It accepts level requests from both requesters, grants one at a time, and drives the memory address, write data and write enable. It holds reads for a fixed memory latency, then returns captured data with a one-cycle valid pulse. It sits between `mips_core` and the memory model, replacing the direct `inst_addr`/`mem_addr` connections.

## Interface
- `XLEN`, 32, data/address width
- `MEM_LAT`, 2, read latency of memory in cycles (legal range ≥1)

- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_b`  in  1  reset, synchronous and active-high
- `halted`  in  1  core halted; blocks new grants
- `if_req`  in  1  fetch request (level)
- `if_addr`  in  XLEN  fetch address
- `if_valid`  out  1  one-cycle pulse; `if_data` valid
- `if_data`  out  XLEN  fetched instruction
- `d_req`  in  1  data request (level)
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  XLEN  data address
- `d_wdata`  in  8×[0:3]  store bytes
- `d_done`  out  1  one-cycle pulse; load data valid or store committed
- `d_rdata`  out  8×[0:3]  load bytes
- `mem_addr`  out  XLEN  memory address
- `mem_data_in`  out  8×[0:3]  memory write bytes
- `mem_write_en`  out  1  memory write strobe
- `mem_data_out`  in  8×[0:3]  memory read bytes
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, IF_RD, D_RD, D_WR.
- **IDLE.** At each edge with `halted`=0, sample the requests.
  - Only `if_req` high → IF_RD.
  - Only `d_req` high → D_RD if `d_we`=0, else D_WR.
  - Both high → the requester not granted last wins. `last_grant` resets to IF, so data wins the first contention.
  - On accept, capture the address, `d_we` and `d_wdata` into registers, and update `last_grant`.
  - `halted`=1 → no accept; any in-flight transaction still completes.
- **IF_RD / D_RD.**
  - `mem_addr` = captured address.
  - Latency counter loads MEM_LAT−1 on accept and decrements each cycle.
  - At the edge where the counter = 0: capture `mem_data_out` into `if_data` (bytes 0..3 → bits 31..0, byte 0 MSB) or into `d_rdata`. Assert `if_valid`/`d_done` for the next cycle and go to IDLE.
- **D_WR.** Lasts one cycle.
  - `mem_write_en`=1, `mem_addr` = captured address, `mem_data_in` = captured `d_wdata`.
  - Next edge → IDLE with `d_done`=1.
- `mem_write_en` is high only in D_WR. `mem_data_in` = 0 outside D_WR. `mem_addr` = 0 in IDLE.
- Requesters hold `req` and their operands stable until their pulse. A requester that still has `req` high in the pulse cycle is treated as making a new request, which makes back-to-back transactions legal.
- Addresses pass through unmodified; no alignment check.
- `if_data`/`d_rdata` hold their last captured value until the next capture.

## Timing
- Reset (`rst_b`=1 at an edge), including mid-transaction: state=IDLE, `last_grant`=IF, counter=0. All outputs are 0 in the following cycle, including `mem_write_en`. An aborted transaction produces no pulse.
- Read latency: request accepted at edge E0 → pulse high during the cycle after edge E0+MEM_LAT. That is MEM_LAT+1 cycles from the first request cycle.
- Write latency: accepted at E0 → `mem_write_en` high in the cycle after E0 → `d_done` high in the cycle after E1.
- A new accept may occur at the edge ending a pulse cycle, so `busy` drops for exactly one cycle between back-to-back transactions.
- `halted` rising during IF_RD/D_RD/D_WR: the transaction finishes normally, then the block stays in IDLE.
- `if_valid` and `d_done` are never high in the same cycle.

## Structure
- Shared `mips_pkg` holds:
  - `arb_state_t` enum {IDLE, IF_RD, D_RD, D_WR}
  - `grant_t` enum {GRANT_IF, GRANT_D}
  - `byte_word_t` (8-bit ×4 array)
  - `MEM_LAT` default constant
- One sub-module: `mem_lat_counter`, a loadable down-counter with `load`, `load_val`, `zero` and width $clog2(MEM_LAT)+1.

## Test plan
- **Single fetch:** `if_req`=1, `if_addr`=0x10, memory returns {0x20,0x08,0x00,0x05}, MEM_LAT=2 → `if_valid` pulse in cycle 3 after the request edge, `if_data`=0x20080005.
- **Store:** `d_req`=1, `d_we`=1, `d_addr`=0x40, `d_wdata`={0xDE,0xAD,0xBE,0xEF} → exactly one cycle of `mem_write_en`=1 with `mem_addr`=0x40, then `d_done` next cycle.
- **Contention:** `if_req` and `d_req` (load) held high continuously → grants alternate D, IF, D, IF, with each pulse MEM_LAT+1 cycles apart.
- **Halt:** assert `halted` during IF_RD → `if_valid` still pulses, then `busy` stays 0 while requests remain high.
- **Reset mid-read:** `rst_b`=1 in the second D_RD cycle → no `d_done`, all outputs 0 next cycle, and the next contention grants data first.
- **MEM_LAT=1 back-to-back:** `if_req` held high for 3 fetches → `if_valid` pulses every 2 cycles with addresses tracking `if_addr`.
